// File: rtl/shift_left_seq.sv
// Iterative lane left-shifter: moves a LANES*LANE_W word left by 0..MAX_SHIFT
// lanes, one lane per clock, filling vacated low lanes with a fill pattern.
module shift_left_seq #(
  parameter int LANES     = 10,
  parameter int LANE_W    = 5,
  parameter int SHIFT_W   = 3,
  parameter int MAX_SHIFT = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES*LANE_W-1:0]   in,
  input  logic [SHIFT_W-1:0]        shift,
  input  logic [LANE_W-1:0]         fill,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LANES*LANE_W-1:0]   out,
  output logic                      out_err
);

  localparam int W = LANES * LANE_W;
  localparam logic [SHIFT_W-1:0] MAX_SHIFT_L = SHIFT_W'(MAX_SHIFT);
  localparam logic [SHIFT_W-1:0] CNT_ONE     = SHIFT_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [W-1:0]         data_q, data_d;
  logic [LANE_W-1:0]    fill_q, fill_d;
  logic [SHIFT_W-1:0]   cnt_q, cnt_d;
  logic [W-1:0]         out_q, out_d;
  logic                 err_q, err_d;
  logic [W-1:0]         data_shifted;

  // One lane step: drop the top lane, insert the captured fill at the bottom.
  assign data_shifted = (data_q << LANE_W) | {{(W-LANE_W){1'b0}}, fill_q};

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    fill_d  = fill_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          data_d = in;
          fill_d = fill;
          cnt_d  = shift;
          if (shift > MAX_SHIFT_L) begin
            err_d   = 1'b1;
            out_d   = in;
            state_d = DONE;
          end else if (shift == {SHIFT_W{1'b0}}) begin
            err_d   = 1'b0;
            out_d   = in;
            state_d = DONE;
          end else begin
            err_d   = 1'b0;
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        data_d = data_shifted;
        cnt_d  = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          out_d   = data_shifted;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      fill_q  <= '0;
      cnt_q   <= '0;
      out_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      fill_q  <= fill_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      err_q   <= err_d;
    end
  end

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == DONE);
  assign out       = out_q;
  assign out_err   = err_q;

endmodule

// File: tb/tb_shift_left_seq.sv
// Randomized bench for shift_left_seq: each request is compared against a
// lane-array reference model for result, error flag, latency and handshake.
module tb_shift_left_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [49:0] in_data;
  logic [2:0]  shift_i;
  logic [4:0]  fill_i;
  logic        out_valid;
  logic        out_ready;
  logic [49:0] out_data;
  logic        out_err;

  int n_checks = 0;
  int n_fail   = 0;

  shift_left_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in        (in_data),
    .shift     (shift_i),
    .fill      (fill_i),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out_data),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: build the result lane by lane from the input lanes.
  function automatic logic [49:0] ref_out(input logic [49:0] d, input int s, input logic [4:0] f);
    logic [4:0]  lanes [10];
    logic [49:0] r;
    if (s > 4) return d;
    for (int i = 0; i < 10; i++) begin
      if (i < s) lanes[i] = f;
      else       lanes[i] = d[(i-s)*5 +: 5];
    end
    r = '0;
    for (int i = 0; i < 10; i++) r[i*5 +: 5] = lanes[i];
    return r;
  endfunction

  task automatic run_txn(input logic [49:0] d, input int s, input logic [4:0] f, input int stall);
    logic [49:0] exp_out;
    logic        exp_err;
    int          exp_lat;
    int          lat;
    exp_out = ref_out(d, s, f);
    exp_err = (s > 4);
    exp_lat = (s == 0 || s > 4) ? 1 : s + 1;

    @(negedge clk);
    check("in_ready_idle", 64'(in_ready), 64'(1));
    in_valid = 1'b1;
    in_data  = d;
    shift_i  = 3'(s);
    fill_i   = f;
    @(posedge clk);
    #1;
    // Inputs after the accepting edge must be ignored.
    in_data  = 50'({$urandom(), $urandom()});
    shift_i  = 3'($urandom_range(0, 7));
    fill_i   = 5'($urandom_range(0, 31));
    in_valid = 1'($urandom_range(0, 1));

    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (!out_valid) check("in_ready_busy", 64'(in_ready), 64'(0));
    end while (!out_valid && lat < 20);

    check("latency", 64'(lat), 64'(exp_lat));
    check("out", 64'(out_data), 64'(exp_out));
    check("out_err", 64'(out_err), 64'(exp_err));
    check("in_ready_done", 64'(in_ready), 64'(0));

    for (int k = 0; k < stall; k++) begin
      @(negedge clk);
      check("stall_valid", 64'(out_valid), 64'(1));
      check("stall_out", 64'(out_data), 64'(exp_out));
      check("stall_err", 64'(out_err), 64'(exp_err));
      check("stall_in_ready", 64'(in_ready), 64'(0));
    end

    out_ready = 1'b1;
    in_valid  = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    check("post_valid", 64'(out_valid), 64'(0));
    check("post_in_ready", 64'(in_ready), 64'(1));
    check("post_out_held", 64'(out_data), 64'(exp_out));
    $display("txn in=%h shift=%0d fill=%h -> out=%h err=%0d lat=%0d stall=%0d",
             d, s, f, out_data, out_err, lat, stall);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b1;
    in_data   = '0;
    shift_i   = '0;
    fill_i    = '0;
    out_ready = 1'b0;

    for (int c = 0; c < 2; c++) begin
      @(posedge clk);
      @(negedge clk);
      check("rst_in_ready", 64'(in_ready), 64'(0));
      check("rst_out_valid", 64'(out_valid), 64'(0));
      check("rst_out", 64'(out_data), 64'(0));
      check("rst_out_err", 64'(out_err), 64'(0));
    end
    in_valid = 1'b0;
    rst      = 1'b0;
    @(negedge clk);
    check("after_rst_in_ready", 64'(in_ready), 64'(1));
    $display("reset sequence done");

    run_txn(50'h0_0000_0000_001F, 2, 5'h1A, 0);
    run_txn(50'h3_FFFF_FFFF_FFFF, 0, 5'h00, 0);
    run_txn(50'h3_FFFF_FFFF_FFFF, 4, 5'h00, 0);
    run_txn(50'h0_0000_0000_1234, 6, 5'h0B, 5);
    run_txn(50'h2_AAAA_5555_AAAA, 5, 5'h11, 1);
    run_txn(50'h1_2345_6789_ABCD, 7, 5'h1F, 0);

    // Reset during the second SHIFT cycle drops the in-flight word.
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 50'h3_1234_5678_9ABC;
    shift_i  = 3'd4;
    fill_i   = 5'h15;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_out", 64'(out_data), 64'(0));
    check("midrst_err", 64'(out_err), 64'(0));
    for (int c = 0; c < 8; c++) begin
      check("midrst_no_valid", 64'(out_valid), 64'(0));
      @(negedge clk);
    end
    $display("mid-shift reset done");
    run_txn(50'h0_0000_0000_0001, 1, 5'h1F, 0);

    for (int t = 0; t < 150; t++) begin
      run_txn(50'({$urandom(), $urandom()}), int'($urandom_range(0, 7)),
              5'($urandom_range(0, 31)), int'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
